// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source result FIFOs and a two-slot round-robin broadcaster.
// Define CDB_BYPASS_EN to let an empty source's incoming result bypass its FIFO.

module cdb_src_fifo #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_pop,
  output logic [CNT_W-1:0]  o_count,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_value
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0]  r_tag [DEPTH];
  logic [DATA_W-1:0] r_val [DEPTH];
  logic [PTR_W-1:0]  r_rd, r_wr;
  logic [CNT_W-1:0]  r_cnt;

  // Pointers wrap naturally since DEPTH is a power of two; count disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_W'(1);
      if (i_pop)  r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !reset && !i_clr) begin
      r_tag[r_wr] <= i_tag;
      r_val[r_wr] <= i_value;
    end
  end

  assign o_count = r_cnt;
  assign o_tag   = r_tag[r_rd];
  assign o_value = r_val[r_rd];
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 8,
  parameter int DATA_W     = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [NUM_SRC-1:0]                  req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]            req_tag,
  input  logic [NUM_SRC*DATA_W-1:0]           req_value,
  output logic [NUM_SRC-1:0]                  req_ready,
  output logic [TAG_W-1:0]                    cdb1_tag,
  output logic [DATA_W-1:0]                   cdb1_value,
  output logic [TAG_W-1:0]                    cdb2_tag,
  output logic [DATA_W-1:0]                   cdb2_value,
  output logic [NUM_SRC+$clog2(FIFO_DEPTH):0] pending
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PEND_W = NUM_SRC + $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0][CNT_W-1:0]  w_cnt;
  logic [NUM_SRC-1:0][TAG_W-1:0]  w_head_tag, w_src_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] w_head_val, w_src_val;
  logic [NUM_SRC-1:0]             w_nonempty, w_byp, w_cand, w_grant, w_push, w_pop;
  logic [IDX_W-1:0]               w_ga, w_gb;
  logic                           w_ga_v, w_gb_v;
  logic [PEND_W-1:0]              w_pend;

  logic [IDX_W-1:0]  r_rr;
  logic [TAG_W-1:0]  r_cdb1_tag, r_cdb2_tag;
  logic [DATA_W-1:0] r_cdb1_val, r_cdb2_val;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [TAG_W-1:0]  w_req_tag;
    logic [DATA_W-1:0] w_req_val;
    assign w_req_tag = req_tag[gi*TAG_W +: TAG_W];
    assign w_req_val = req_value[gi*DATA_W +: DATA_W];

    assign w_nonempty[gi] = (w_cnt[gi] != '0);
    assign req_ready[gi]  = (w_cnt[gi] < CNT_W'(FIFO_DEPTH));
`ifdef CDB_BYPASS_EN
    assign w_byp[gi] = !w_nonempty[gi] && req_valid[gi] && (w_req_tag != '0);
`else
    assign w_byp[gi] = 1'b0;
`endif
    assign w_cand[gi]    = w_nonempty[gi] | w_byp[gi];
    assign w_src_tag[gi] = w_nonempty[gi] ? w_head_tag[gi] : w_req_tag;
    assign w_src_val[gi] = w_nonempty[gi] ? w_head_val[gi] : w_req_val;
    assign w_grant[gi]   = (w_ga_v && (w_ga == IDX_W'(gi))) || (w_gb_v && (w_gb == IDX_W'(gi)));
    assign w_pop[gi]     = w_grant[gi] && w_nonempty[gi] && !flush;
    // Tag 0 is handshaked but dropped; a granted bypass never lands in the FIFO.
    assign w_push[gi]    = req_valid[gi] && req_ready[gi] && (w_req_tag != '0) && !flush
                           && !(w_grant[gi] && w_byp[gi]);

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (flush),
      .i_push  (w_push[gi]),
      .i_tag   (w_req_tag),
      .i_value (w_req_val),
      .i_pop   (w_pop[gi]),
      .o_count (w_cnt[gi]),
      .o_tag   (w_head_tag[gi]),
      .o_value (w_head_val[gi])
    );
  end

  // First two distinct candidates scanning from r_rr with wrap.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] idx;
    w_ga_v = 1'b0;
    w_gb_v = 1'b0;
    w_ga   = '0;
    w_gb   = '0;
    j      = 0;
    idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(r_rr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      idx = IDX_W'(j);
      if (w_cand[idx]) begin
        if (!w_ga_v) begin
          w_ga_v = 1'b1;
          w_ga   = idx;
        end else if (!w_gb_v) begin
          w_gb_v = 1'b1;
          w_gb   = idx;
        end
      end
    end
  end

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_SRC - 1) ? '0 : i + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rr       <= '0;
      r_cdb1_tag <= '0;
      r_cdb1_val <= '0;
      r_cdb2_tag <= '0;
      r_cdb2_val <= '0;
    end else begin
      r_cdb1_tag <= w_ga_v ? w_src_tag[w_ga] : '0;
      r_cdb1_val <= w_ga_v ? w_src_val[w_ga] : '0;
      r_cdb2_tag <= w_gb_v ? w_src_tag[w_gb] : '0;
      r_cdb2_val <= w_gb_v ? w_src_val[w_gb] : '0;
      if (w_gb_v)      r_rr <= rr_next(w_gb);
      else if (w_ga_v) r_rr <= rr_next(w_ga);
    end
  end

  always_comb begin
    w_pend = '0;
    for (int k = 0; k < NUM_SRC; k++) w_pend = w_pend + PEND_W'(w_cnt[k]);
  end

  assign pending    = w_pend;
  assign cdb1_tag   = r_cdb1_tag;
  assign cdb1_value = r_cdb1_val;
  assign cdb2_tag   = r_cdb2_tag;
  assign cdb2_value = r_cdb2_val;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, latency sequence, random vs queue model.
module tb_cdb_arbiter;
  localparam int NS = 4;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0, flush = 1'b0;
  logic [NS-1:0]  req_valid = '0;
  logic [NS*8-1:0]  req_tag = '0;
  logic [NS*32-1:0] req_value = '0;
  logic [NS-1:0]  req_ready;
  logic [7:0]     cdb1_tag, cdb2_tag;
  logic [31:0]    cdb1_value, cdb2_value;
  logic [5:0]     pending;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready),
    .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  // Reference model: one queue per source plus the round-robin start index.
  logic [7:0]  mq_t [NS][$];
  logic [31:0] mq_d [NS][$];
  int          m_rr = 0;
  logic [7:0]  m_c1t = 0, m_c2t = 0;
  logic [31:0] m_c1v = 0, m_c2v = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] vf(input logic [7:0] t);
    return {8'hA5, t, 8'h3C, t};
  endfunction

  task automatic model_edge(input logic rst, input logic fl, input logic [NS-1:0] v,
                            input logic [NS*8-1:0] t, input logic [NS*32-1:0] d);
    bit   rdy[NS], cand[NS], byp[NS], gr[NS];
    int   g[$];
    int   j;
    logic [7:0]  tt;
    logic [31:0] dd;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = mq_t[i].size() < DEPTH;
      byp[i] = 0;
      gr[i]  = 0;
      cand[i] = mq_t[i].size() != 0;
`ifdef CDB_BYPASS_EN
      if (mq_t[i].size() == 0 && v[i] && t[i*8 +: 8] != 0) begin
        cand[i] = 1;
        byp[i]  = 1;
      end
`endif
    end
    if (rst || fl) begin
      for (int i = 0; i < NS; i++) begin
        mq_t[i].delete();
        mq_d[i].delete();
      end
      m_rr = 0; m_c1t = 0; m_c1v = 0; m_c2t = 0; m_c2v = 0;
      return;
    end
    for (int k = 0; k < NS; k++) begin
      j = (m_rr + k) % NS;
      if (cand[j] && g.size() < 2) g.push_back(j);
    end
    m_c1t = 0; m_c1v = 0; m_c2t = 0; m_c2v = 0;
    for (int n = 0; n < g.size(); n++) begin
      j = g[n];
      gr[j] = 1;
      if (byp[j]) begin
        tt = t[j*8 +: 8];
        dd = d[j*32 +: 32];
      end else begin
        tt = mq_t[j].pop_front();
        dd = mq_d[j].pop_front();
      end
      if (n == 0) begin m_c1t = tt; m_c1v = dd; end
      else        begin m_c2t = tt; m_c2v = dd; end
    end
    for (int i = 0; i < NS; i++)
      if (v[i] && rdy[i] && t[i*8 +: 8] != 0 && !(byp[i] && gr[i])) begin
        mq_t[i].push_back(t[i*8 +: 8]);
        mq_d[i].push_back(d[i*32 +: 32]);
      end
    if (g.size() != 0) m_rr = (g[g.size()-1] + 1) % NS;
  endtask

  function automatic logic [5:0] m_pend();
    int s = 0;
    for (int i = 0; i < NS; i++) s += mq_t[i].size();
    return 6'(s);
  endfunction

  function automatic logic [NS-1:0] m_rdy();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = mq_t[i].size() < DEPTH;
    return r;
  endfunction

  task automatic step(input logic rst, input logic fl, input logic [NS-1:0] v,
                      input logic [NS*8-1:0] t, input logic [NS*32-1:0] d);
    reset = rst; flush = fl; req_valid = v; req_tag = t; req_value = d;
    @(posedge clk);
    model_edge(rst, fl, v, t, d);
    #1;
    reset = 0; flush = 0; req_valid = '0;
  endtask

  task automatic chk_model(input string pfx);
    chk({pfx, "_c1tag"}, 64'(cdb1_tag), 64'(m_c1t));
    chk({pfx, "_c1val"}, 64'(cdb1_value), 64'(m_c1v));
    chk({pfx, "_c2tag"}, 64'(cdb2_tag), 64'(m_c2t));
    chk({pfx, "_c2val"}, 64'(cdb2_value), 64'(m_c2v));
    chk({pfx, "_pend"}, 64'(pending), 64'(m_pend()));
    chk({pfx, "_ready"}, 64'(req_ready), 64'(m_rdy()));
  endtask

  typedef struct {
    logic          rst, fl;
    logic [NS-1:0] v;
    logic [31:0]   t;
    logic [7:0]    c1t, c2t;
    logic [5:0]    pend;
    logic [NS-1:0] rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic fl, input logic [3:0] v,
                     input logic [7:0] t3, t2, t1, t0,
                     input logic [7:0] c1, c2, input logic [5:0] p, input logic [3:0] r);
    vec_t e;
    e.rst = rst; e.fl = fl; e.v = v; e.t = {t3, t2, t1, t0};
    e.c1t = c1; e.c2t = c2; e.pend = p; e.rdy = r;
    tbl.push_back(e);
  endtask

  initial begin
    logic [NS*32-1:0] dv;
    logic [NS*8-1:0]  tv;
    logic [NS-1:0]    vv;
    string            nm;

`ifndef CDB_BYPASS_EN
    //  rst fl  v       t3    t2    t1    t0    c1    c2    pend rdy
    add(1, 0, 4'b0000, 0,    0,    0,    0,    0,    0,    0, 4'hF);
    for (int i = 0; i < 5; i++) add(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    add(0, 0, 4'b0111, 0,    8'd7, 8'd6, 8'd5, 0,    0,    3, 4'hF);
    add(0, 0, 4'b0000, 0,    0,    0,    0,    8'd5, 8'd6, 1, 4'hF);
    add(0, 0, 4'b0000, 0,    0,    0,    0,    8'd7, 0,    0, 4'hF);
    add(0, 0, 4'b0000, 0,    0,    0,    0,    0,    0,    0, 4'hF);
    add(0, 0, 4'b1000, 8'd1, 0,    0,    0,    0,    0,    1, 4'hF);
    add(0, 0, 4'b1000, 8'd2, 0,    0,    0,    8'd1, 0,    1, 4'hF);
    add(0, 0, 4'b1000, 8'd3, 0,    0,    0,    8'd2, 0,    1, 4'hF);
    add(0, 0, 4'b0000, 0,    0,    0,    0,    8'd3, 0,    0, 4'hF);
    add(0, 0, 4'b0000, 0,    0,    0,    0,    0,    0,    0, 4'hF);
    add(0, 0, 4'b1111, 8'h41, 8'h31, 8'h21, 8'h11, 0,     0,     4, 4'hF);
    add(0, 0, 4'b1111, 8'h42, 8'h32, 8'h22, 8'h12, 8'h11, 8'h21, 6, 4'b0011);
    add(0, 0, 4'b1111, 8'h43, 8'h33, 8'h23, 8'h13, 8'h31, 8'h41, 6, 4'b1100);
    add(0, 0, 4'b1111, 8'h43, 8'h33, 8'h24, 8'h14, 8'h12, 8'h22, 6, 4'b0011);
    add(0, 0, 4'b1111, 8'h44, 8'h34, 8'h24, 8'h14, 8'h32, 8'h42, 6, 4'b1100);
    add(0, 0, 4'b0100, 0,     8'h34, 0,     0,     8'h13, 8'h23, 5, 4'b1011);
    add(0, 1, 4'b0001, 0,     0,     0,     8'd9,  0,     0,     0, 4'hF);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    add(0, 0, 4'b0001, 0,     0,     0,     0,     0,     0,     0, 4'hF);
    add(0, 0, 4'b0000, 0,     0,     0,     0,     0,     0,     0, 4'hF);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int i = 0; i < NS; i++) dv[i*32 +: 32] = vf(tbl[r].t[i*8 +: 8]);
      step(tbl[r].rst, tbl[r].fl, tbl[r].v, tbl[r].t, dv);
      nm = $sformatf("row%0d", r);
      chk({nm, "_c1tag"}, 64'(cdb1_tag), 64'(tbl[r].c1t));
      chk({nm, "_c1val"}, 64'(cdb1_value), 64'((tbl[r].c1t == 0) ? 32'h0 : vf(tbl[r].c1t)));
      chk({nm, "_c2tag"}, 64'(cdb2_tag), 64'(tbl[r].c2t));
      chk({nm, "_c2val"}, 64'(cdb2_value), 64'((tbl[r].c2t == 0) ? 32'h0 : vf(tbl[r].c2t)));
      chk({nm, "_pend"}, 64'(pending), 64'(tbl[r].pend));
      chk({nm, "_ready"}, 64'(req_ready), 64'(tbl[r].rdy));
    end
`endif

    // Enqueue-to-broadcast latency from an idle, empty state.
    step(1, 0, '0, '0, '0);
    tv = '0; tv[2*8 +: 8] = 8'd4;
    dv = '0; dv[2*32 +: 32] = vf(8'd4);
    step(0, 0, 4'b0100, tv, dv);
`ifdef CDB_BYPASS_EN
    chk("lat_edge1_tag", 64'(cdb1_tag), 64'd4);
    chk("lat_edge1_pend", 64'(pending), 64'd0);
    step(0, 0, '0, '0, '0);
    chk("lat_edge2_tag", 64'(cdb1_tag), 64'd0);
`else
    chk("lat_edge1_tag", 64'(cdb1_tag), 64'd0);
    chk("lat_edge1_pend", 64'(pending), 64'd1);
    step(0, 0, '0, '0, '0);
    chk("lat_edge2_tag", 64'(cdb1_tag), 64'd4);
    chk("lat_edge2_pend", 64'(pending), 64'd0);
`endif
    chk_model("lat_model");

    // Randomized traffic against the queue model.
    step(1, 0, '0, '0, '0);
    for (int c = 0; c < 800; c++) begin
      vv = 4'($urandom);
      for (int i = 0; i < NS; i++) begin
        tv[i*8 +: 8]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        dv[i*32 +: 32] = $urandom;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, vv, tv, dv);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
